// File: rtl/risc_mc_ctrl.sv
// -----------------------------------------------------------------------------
// risc_mc_ctrl -- multi-cycle control sequencer for the RISC datapath.
//
// Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and back to
// FETCH. The sequencer drives the PC/IR/register-file enables, the ALU
// operation, the address/write-back selects and the shared memory port
// handshake. Retired instructions are counted, and the core stops in HALT
// either on a HALT instruction or when a memory request times out.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   opcode     in   IR[15:12], valid from DECODE onward
//   zero       in   ALU zero flag, only looked at in EXEC
//   mem_ready  in   memory completes the current request this cycle
//   mem_req    out  memory request strobe
//   mem_we     out  memory write (ST data phase)
//   addr_sel   out  0 = PC drives the address, 1 = ALU result
//   ir_we      out  load IR
//   pc_we      out  load PC
//   pc_src     out  0 = PC+1, 1 = branch target, 2 = jump target
//   alu_op     out  0 ADD, 1 SUB, 2 AND, 3 OR
//   rf_we      out  register-file write
//   wb_sel     out  0 = ALU result, 1 = memory data
//   halted     out  core stopped
//   bus_err    out  sticky memory-timeout flag
//   illegal    out  one-cycle pulse on an undefined opcode
//   instr_cnt  out  retired-instruction count, wraps modulo 2^CNT_W
//
// All outputs are combinational from state, opcode, zero and mem_ready, and
// are forced to 0 while rst is high.
// -----------------------------------------------------------------------------
module risc_mc_ctrl #(
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             halted,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    // Opcode map; 8..14 are undefined.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;

    // The wait counter must be able to hold MEM_WAIT_MAX itself.
    localparam int              WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  cnt_q;
    logic              bus_err_q;
    logic              retire;     // last cycle of an instruction
    logic              timeout;    // memory request abandoned this cycle

    // -------------------------------------------------------------------------
    // State register, retire counter, wait counter, sticky bus error.
    // -------------------------------------------------------------------------
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later statements see new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state <= state_next;

            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (timeout) begin
                bus_err_q <= 1'b1;
            end

            // wait_cnt holds the number of mem_ready=0 cycles already spent in
            // the current FETCH/MEM visit. Any state change clears it, which
            // covers every entry into FETCH or MEM. Saturating keeps it from
            // wrapping while parked in HALT.
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (!mem_ready && wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs.
    // -------------------------------------------------------------------------
    // NOTE: every signal written below gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        timeout    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_INC;
        alu_op     = ALU_ADD;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        illegal    = 1'b0;
        halted     = (state == S_HALT);
        bus_err    = bus_err_q;
        instr_cnt  = cnt_q;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    // mem_ready in the cycle the wait count equals the limit
                    // still wins, because it is tested before the timeout.
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    timeout    = 1'b1;
                    state_next = S_HALT;
                end
            end

            S_DECODE: begin
                state_next = S_EXEC;
            end

            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        alu_op     = opcode[1:0];
                        state_next = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        alu_op     = ALU_ADD;      // base + offset
                        state_next = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op     = ALU_SUB;
                        if (zero) begin
                            pc_we  = 1'b1;
                            pc_src = PC_BRANCH;
                        end
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_we      = 1'b1;
                        pc_src     = PC_JUMP;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_HALT: begin
                        retire     = 1'b1;
                        state_next = S_HALT;
                    end
                    default: begin
                        // Undefined opcode: flag it, skip it, do not count it.
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_ST);
                if (mem_ready) begin
                    if (opcode == OP_ST) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_cnt == WAIT_LIMIT) begin
                    timeout    = 1'b1;
                    state_next = S_HALT;
                end
            end

            S_WB: begin
                rf_we      = 1'b1;
                wb_sel     = (opcode == OP_LD);
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_HALT: begin
                state_next = S_HALT;   // only rst leaves HALT
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Reset dominates every output, so an instruction caught mid-flight
        // never produces a late pc_we, rf_we or memory write.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            addr_sel  = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_src    = PC_INC;
            alu_op    = ALU_ADD;
            rf_we     = 1'b0;
            wb_sel    = 1'b0;
            illegal   = 1'b0;
            halted    = 1'b0;
            bus_err   = 1'b0;
            instr_cnt = '0;
        end
    end

endmodule

// File: tb/tb_risc_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_risc_mc_ctrl -- self-checking bench for risc_mc_ctrl.
//
// A directed per-cycle vector table covers each instruction class, then
// hand-written sequences cover HALT hold, fetch/memory timeout and its
// boundary, reset in the middle of a store, and counter wrap. A randomized
// phase issues instructions with random wait states and compares every cycle
// against an instruction-level reference model. Inputs are driven on the
// falling edge and outputs sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_risc_mc_ctrl;

    localparam int TB_CNT_W = 4;
    localparam int TB_WAIT  = 8;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       rf_we;
        logic       wb_sel;
        logic       halted;
        logic       bus_err;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic                rst;
        logic [3:0]          opcode;
        logic                zero;
        logic                mem_ready;
        outs_t               exp;
        logic [TB_CNT_W-1:0] cnt;
        string               name;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          opcode;
    logic                zero;
    logic                mem_ready;
    logic                mem_req, mem_we, addr_sel, ir_we, pc_we;
    logic [1:0]          pc_src, alu_op;
    logic                rf_we, wb_sel, halted, bus_err, illegal;
    logic [TB_CNT_W-1:0] instr_cnt;
    outs_t               act;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;   // reference retired-instruction count

    vec_t vecs[$];

    always #5 clk = ~clk;

    risc_mc_ctrl #(
        .CNT_W        (TB_CNT_W),
        .MEM_WAIT_MAX (TB_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .halted    (halted),
        .bus_err   (bus_err),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    assign act = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_op,
                  rf_we, wb_sel, halted, bus_err, illegal};

    function automatic outs_t mk(input logic mreq, input logic mwe, input logic asel,
                                 input logic irwe, input logic pcwe, input logic [1:0] psrc,
                                 input logic [1:0] aop, input logic rfwe, input logic wbs,
                                 input logic hlt, input logic berr, input logic ill);
        return {mreq, mwe, asel, irwe, pcwe, psrc, aop, rfwe, wbs, hlt, berr, ill};
    endfunction

    // Frequently used expected output patterns.
    outs_t o_none, o_fwait, o_fetch, o_memrd, o_memwr, o_wb_alu, o_wb_ld, o_halt, o_berr;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, let the
    // combinational outputs settle, compare, then the next rising edge follows.
    task automatic step(input logic r, input logic [3:0] op, input logic z, input logic rdy,
                        input outs_t e, input logic [TB_CNT_W-1:0] ecnt, input string name);
        @(negedge clk);
        rst       = r;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        #1;
        check(name, 32'(act), 32'(e));
        check({name, "/cnt"}, 32'(instr_cnt), 32'(ecnt));
    endtask

    task automatic add(input logic r, input logic [3:0] op, input logic z, input logic rdy,
                       input outs_t e, input int ecnt, input string name);
        vec_t v;
        v.rst = r; v.opcode = op; v.zero = z; v.mem_ready = rdy;
        v.exp = e; v.cnt = TB_CNT_W'(ecnt); v.name = name;
        vecs.push_back(v);
    endtask

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference model at instruction level: given an opcode, the zero flag
    // seen in EXEC and the number of wait cycles in FETCH and MEM, it lays out
    // the cycles the instruction must take and what each one must show.
    task automatic run_instr(input logic [3:0] op, input logic z, input int fwait,
                             input int mwait, input string tag);
        outs_t e;
        bit    is_alu, is_mem, retire_exec;
        is_alu      = (op <= 4'd3);
        is_mem      = (op == 4'd4) || (op == 4'd5);
        retire_exec = (op == 4'd6) || (op == 4'd7) || (op == 4'd15);

        for (int i = 0; i < fwait; i++)
            step(1'b0, rnd4(), rnd1(), 1'b0, o_fwait, TB_CNT_W'(m_cnt), {tag, "_fw"});
        step(1'b0, rnd4(), rnd1(), 1'b1, o_fetch, TB_CNT_W'(m_cnt), {tag, "_f"});
        step(1'b0, op, rnd1(), rnd1(), o_none, TB_CNT_W'(m_cnt), {tag, "_d"});

        e = o_none;
        if (is_alu)          e.alu_op = op[1:0];
        else if (op == 4'd6) begin
            e.alu_op = 2'd1;
            if (z) begin e.pc_we = 1'b1; e.pc_src = 2'd1; end
        end else if (op == 4'd7) begin
            e.pc_we = 1'b1; e.pc_src = 2'd2;
        end else if (!is_mem && op != 4'd15) e.illegal = 1'b1;
        step(1'b0, op, z, rnd1(), e, TB_CNT_W'(m_cnt), {tag, "_e"});
        if (retire_exec) m_cnt++;

        if (is_mem) begin
            e = (op == 4'd5) ? o_memwr : o_memrd;
            for (int i = 0; i < mwait; i++)
                step(1'b0, op, rnd1(), 1'b0, e, TB_CNT_W'(m_cnt), {tag, "_mw"});
            step(1'b0, op, rnd1(), 1'b1, e, TB_CNT_W'(m_cnt), {tag, "_m"});
            if (op == 4'd5) m_cnt++;
        end

        if (is_alu || op == 4'd4) begin
            step(1'b0, op, rnd1(), rnd1(), (op == 4'd4) ? o_wb_ld : o_wb_alu,
                 TB_CNT_W'(m_cnt), {tag, "_wb"});
            m_cnt++;
        end
    endtask

    initial begin
        logic [3:0] op;
        int         r, fw, mw;

        o_none   = '0;
        o_fwait  = mk(1,0,0,0,0,2'd0,2'd0,0,0,0,0,0);
        o_fetch  = mk(1,0,0,1,1,2'd0,2'd0,0,0,0,0,0);
        o_memrd  = mk(1,0,1,0,0,2'd0,2'd0,0,0,0,0,0);
        o_memwr  = mk(1,1,1,0,0,2'd0,2'd0,0,0,0,0,0);
        o_wb_alu = mk(0,0,0,0,0,2'd0,2'd0,1,0,0,0,0);
        o_wb_ld  = mk(0,0,0,0,0,2'd0,2'd0,1,1,0,0,0);
        o_halt   = mk(0,0,0,0,0,2'd0,2'd0,0,0,1,0,0);
        o_berr   = mk(0,0,0,0,0,2'd0,2'd0,0,0,1,1,0);

        rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;

        // ---------------- directed vector table ----------------
        add(1, 4'd0, 0, 1, o_none, 0, "rst0");
        add(1, 4'd0, 0, 1, o_none, 0, "rst1");
        // ADD, no wait: 4 cycles
        add(0, 4'hF, 1, 1, o_fetch,  0, "add_f");
        add(0, 4'd0, 1, 1, o_none,   0, "add_d");
        add(0, 4'd0, 1, 1, o_none,   0, "add_e");
        add(0, 4'd0, 1, 1, o_wb_alu, 0, "add_wb");
        // SUB
        add(0, 4'd3, 0, 1, o_fetch, 1, "sub_f");
        add(0, 4'd1, 0, 1, o_none,  1, "sub_d");
        add(0, 4'd1, 0, 1, mk(0,0,0,0,0,2'd0,2'd1,0,0,0,0,0), 1, "sub_e");
        add(0, 4'd1, 1, 0, o_wb_alu, 1, "sub_wb");
        // LD, three MEM wait cycles: 8 cycles
        add(0, 4'd0, 0, 1, o_fetch,  2, "ld_f");
        add(0, 4'd4, 0, 1, o_none,   2, "ld_d");
        add(0, 4'd4, 1, 1, o_none,   2, "ld_e");
        add(0, 4'd4, 0, 0, o_memrd,  2, "ld_mw1");
        add(0, 4'd4, 0, 0, o_memrd,  2, "ld_mw2");
        add(0, 4'd4, 0, 0, o_memrd,  2, "ld_mw3");
        add(0, 4'd4, 0, 1, o_memrd,  2, "ld_m");
        add(0, 4'd4, 0, 1, o_wb_ld,  2, "ld_wb");
        // BEQ taken, then not taken
        add(0, 4'd0, 0, 1, o_fetch, 3, "beq1_f");
        add(0, 4'd6, 0, 1, o_none,  3, "beq1_d");
        add(0, 4'd6, 1, 1, mk(0,0,0,0,1,2'd1,2'd1,0,0,0,0,0), 3, "beq1_e");
        add(0, 4'd6, 1, 1, o_fetch, 4, "beq0_f");
        add(0, 4'd6, 1, 1, o_none,  4, "beq0_d");
        add(0, 4'd6, 0, 1, mk(0,0,0,0,0,2'd0,2'd1,0,0,0,0,0), 4, "beq0_e");
        // JMP
        add(0, 4'd2, 0, 1, o_fetch, 5, "jmp_f");
        add(0, 4'd7, 0, 1, o_none,  5, "jmp_d");
        add(0, 4'd7, 1, 1, mk(0,0,0,0,1,2'd2,2'd0,0,0,0,0,0), 5, "jmp_e");
        // ST, no wait
        add(0, 4'd1, 0, 1, o_fetch, 6, "st_f");
        add(0, 4'd5, 0, 1, o_none,  6, "st_d");
        add(0, 4'd5, 0, 1, o_none,  6, "st_e");
        add(0, 4'd5, 0, 1, o_memwr, 6, "st_m");
        // Illegal opcode 9: pulse, not counted
        add(0, 4'd0, 0, 1, o_fetch, 7, "ill_f");
        add(0, 4'd9, 0, 1, o_none,  7, "ill_d");
        add(0, 4'd9, 0, 1, mk(0,0,0,0,0,2'd0,2'd0,0,0,0,0,1), 7, "ill_e");
        // HALT
        add(0, 4'hF, 0, 1, o_fetch, 7, "hlt_f");
        add(0, 4'hF, 0, 1, o_none,  7, "hlt_d");
        add(0, 4'hF, 0, 1, o_none,  7, "hlt_e");
        add(0, 4'hF, 0, 1, o_halt,  8, "hlt_h");

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].opcode, vecs[i].zero, vecs[i].mem_ready,
                 vecs[i].exp, vecs[i].cnt, vecs[i].name);

        // HALT holds with every enable low, whatever the inputs do.
        for (int i = 0; i < 22; i++)
            step(1'b0, rnd4(), rnd1(), rnd1(), o_halt, 4'd8, "hlt_hold");
        step(1'b1, 4'd0, 0, 1, o_none, 4'd0, "hlt_rst");

        // ---------------- FETCH timeout ----------------
        // Eight no-ready cycles are tolerated; no ready on the ninth drops the request.
        for (int i = 0; i < TB_WAIT + 1; i++)
            step(1'b0, rnd4(), rnd1(), 1'b0, o_fwait, 4'd0, "fto_wait");
        step(1'b0, rnd4(), rnd1(), 1'b1, o_berr, 4'd0, "fto_halt");
        step(1'b0, rnd4(), rnd1(), 1'b0, o_berr, 4'd0, "fto_hold");
        step(1'b1, 4'd0, 0, 0, o_none, 4'd0, "fto_rst");

        // ---------------- FETCH timeout boundary ----------------
        for (int i = 0; i < TB_WAIT; i++)
            step(1'b0, rnd4(), rnd1(), 1'b0, o_fwait, 4'd0, "fbd_wait");
        step(1'b0, rnd4(), 0, 1'b1, o_fetch, 4'd0, "fbd_f");
        step(1'b0, 4'd0, 0, 1'b0, o_none, 4'd0, "fbd_d");
        step(1'b0, 4'd0, 0, 1'b0, o_none, 4'd0, "fbd_e");
        step(1'b0, 4'd0, 0, 1'b0, o_wb_alu, 4'd0, "fbd_wb");
        step(1'b0, 4'd0, 0, 1'b1, o_fetch, 4'd1, "fbd_next");

        // ---------------- MEM timeout on a store ----------------
        step(1'b0, 4'd5, 0, 1'b0, o_none, 4'd1, "mto_d");
        step(1'b0, 4'd5, 0, 1'b0, o_none, 4'd1, "mto_e");
        for (int i = 0; i < TB_WAIT + 1; i++)
            step(1'b0, 4'd5, rnd1(), 1'b0, o_memwr, 4'd1, "mto_wait");
        step(1'b0, 4'd5, 0, 1'b1, o_berr, 4'd1, "mto_halt");

        // ---------------- reset during ST MEM ----------------
        step(1'b1, 4'd5, 0, 1'b1, o_none, 4'd0, "rmid_rst0");
        step(1'b0, 4'd5, 0, 1'b1, o_fetch, 4'd0, "rmid_f");
        step(1'b0, 4'd5, 0, 1'b0, o_none, 4'd0, "rmid_d");
        step(1'b0, 4'd5, 0, 1'b0, o_none, 4'd0, "rmid_e");
        step(1'b0, 4'd5, 0, 1'b0, o_memwr, 4'd0, "rmid_m");
        step(1'b1, 4'd5, 0, 1'b1, o_none, 4'd0, "rmid_rst");
        step(1'b0, 4'd5, 0, 1'b0, o_fwait, 4'd0, "rmid_f2");
        step(1'b1, 4'd0, 0, 1'b0, o_none, 4'd0, "wrap_rst");

        // ---------------- 17 ADDs wrap a 4-bit counter to 1 ----------------
        m_cnt = 0;
        for (int i = 0; i < 17; i++)
            run_instr(4'd0, 1'b0, 0, 0, "wrap");
        step(1'b0, 4'd0, 0, 1'b1, o_fetch, 4'd1, "wrap_cnt");
        step(1'b1, 4'd0, 0, 1'b0, o_none, 4'd0, "rnd_rst");

        // ---------------- randomized instruction stream ----------------
        m_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            r  = int'($urandom_range(0, 9));
            op = (r < 8) ? 4'(r) : 4'($urandom_range(8, 14));
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TB_WAIT)) : 0;
            mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TB_WAIT)) : 0;
            run_instr(op, rnd1(), fw, mw, "rnd");
        end
        // A final HALT from the random stream's state.
        run_instr(4'hF, 1'b0, 0, 0, "rnd_halt");
        step(1'b0, rnd4(), rnd1(), rnd1(), o_halt, TB_CNT_W'(m_cnt), "rnd_halted");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
